// File: rtl/noc_pkg.sv
// Shared types for the GIN tag sequencer: FSM state encoding and the buffered entry.
// The entry field widths below fix the buffer word layout and match the default widths
// of gin_tag_sequencer. Instantiate the sequencer with data or tag widths no larger than
// these, or wider inputs are truncated when they are buffered.
package noc_pkg;

  localparam int unsigned GinDataWidth   = 64;
  localparam int unsigned GinRowTagWidth = 4;
  localparam int unsigned GinColTagWidth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } gin_seq_state_e;

  typedef struct packed {
    logic [GinDataWidth-1:0]   data;
    logic [GinRowTagWidth-1:0] row_tag;
    logic [GinColTagWidth-1:0] col_tag;
  } gin_entry_t;

endpackage

// File: rtl/gin_seq_fifo.sv
// Synchronous FIFO of tagged GIN entries, power-of-two depth, synchronous active-high reset.
// A write is accepted while full when a read happens in the same cycle.
module gin_seq_fifo
  import noc_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  gin_entry_t wdata_i,
  input  logic       rd_i,
  output gin_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       last_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  gin_entry_t       mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == (AddrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == (AddrW + 1)'(1));
  assign rdata_o = mem_q[rptr_q];

  assign rd_en = rd_i && !empty_o;
  assign wr_en = wr_i && (!full_o || rd_en);

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      wptr_d = wptr_q + AddrW'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + AddrW'(1);
    end
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + (AddrW + 1)'(1);
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - (AddrW + 1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/gin_tag_sequencer.sv
// GIN tag sequencer: streams words from the global buffer into the GIN, stamping each word
// with a row/column tag that walks a (rows x cols x words-per-tag) pass.
// Optional feature: define GIN_SEQ_STALL_CNT_EN to add the 32-bit stall_cnt output.
module gin_tag_sequencer
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ROW_TAG_WIDTH = 4,
  parameter int unsigned COL_TAG_WIDTH = 4,
  parameter int unsigned WPT_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_row_last,
  input  logic [COL_TAG_WIDTH-1:0] cfg_col_last,
  input  logic [WPT_WIDTH-1:0]     cfg_wpt_last,
  input  logic                     src_valid,
  input  logic [DATA_WIDTH-1:0]    src_data,
  output logic                     src_ready,
  output logic                     gin_enable,
  output logic [DATA_WIDTH-1:0]    gin_data,
  output logic [ROW_TAG_WIDTH-1:0] gin_row_tag,
  output logic [COL_TAG_WIDTH-1:0] gin_col_tag,
  input  logic                     gin_ready,
`ifdef GIN_SEQ_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic                     busy,
  output logic                     done
);

  // Wide enough for (2^R)*(2^C)*(2^W) words without truncation.
  localparam int unsigned TotW = ROW_TAG_WIDTH + COL_TAG_WIDTH + WPT_WIDTH + 1;

  gin_seq_state_e           state_q, state_d;
  logic [TotW-1:0]          total_q, total_d;
  logic [TotW-1:0]          acc_q, acc_d;
  logic [ROW_TAG_WIDTH-1:0] row_q, row_d;
  logic [COL_TAG_WIDTH-1:0] col_q, col_d;
  logic [WPT_WIDTH-1:0]     wpt_q, wpt_d;
  logic [COL_TAG_WIDTH-1:0] col_last_q, col_last_d;
  logic [WPT_WIDTH-1:0]     wpt_last_q, wpt_last_d;

  logic       start_accept;
  logic       src_fire, gin_fire;
  logic       fifo_full, fifo_empty, fifo_last;
  gin_entry_t wr_entry, rd_entry;

  assign start_accept = (state_q == StIdle) && start;
  assign src_ready    = (state_q == StRun) && !fifo_full && (acc_q < total_q);
  assign src_fire     = src_valid && src_ready;
  assign gin_enable   = !fifo_empty;
  assign gin_fire     = gin_enable && gin_ready;
  assign busy         = (state_q != StIdle);

  // Tags are stamped at write time so they travel with the word through the buffer.
  always_comb begin
    wr_entry         = '0;
    wr_entry.data    = GinDataWidth'(src_data);
    wr_entry.row_tag = GinRowTagWidth'(row_q);
    wr_entry.col_tag = GinColTagWidth'(col_q);
  end

  assign gin_data    = DATA_WIDTH'(rd_entry.data);
  assign gin_row_tag = ROW_TAG_WIDTH'(rd_entry.row_tag);
  assign gin_col_tag = COL_TAG_WIDTH'(rd_entry.col_tag);

  gin_seq_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .wr_i    (src_fire),
    .wdata_i (wr_entry),
    .rd_i    (gin_fire),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  // Pass FSM, tag walk and done pulse.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    acc_d      = acc_q;
    row_d      = row_q;
    col_d      = col_q;
    wpt_d      = wpt_q;
    col_last_d = col_last_q;
    wpt_last_d = wpt_last_q;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          total_d    = (TotW'(cfg_row_last) + TotW'(1)) *
                       (TotW'(cfg_col_last) + TotW'(1)) *
                       (TotW'(cfg_wpt_last) + TotW'(1));
          acc_d      = '0;
          row_d      = '0;
          col_d      = '0;
          wpt_d      = '0;
          col_last_d = cfg_col_last;
          wpt_last_d = cfg_wpt_last;
        end
      end
      StRun: begin
        if (src_fire) begin
          acc_d = acc_q + TotW'(1);
          if (wpt_q == wpt_last_q) begin
            wpt_d = '0;
            if (col_q == col_last_q) begin
              col_d = '0;
              row_d = row_q + ROW_TAG_WIDTH'(1);
            end else begin
              col_d = col_q + COL_TAG_WIDTH'(1);
            end
          end else begin
            wpt_d = wpt_q + WPT_WIDTH'(1);
          end
          if (acc_q == total_q - TotW'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // All words are buffered; the pass ends as the last one leaves.
        if (gin_fire && fifo_last) begin
          state_d = StIdle;
          done    = !reset;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      acc_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wpt_q      <= '0;
      col_last_q <= '0;
      wpt_last_q <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wpt_q      <= wpt_d;
      col_last_q <= col_last_d;
      wpt_last_q <= wpt_last_d;
    end
  end

`ifdef GIN_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the GIN holds off a presented word.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_accept) begin
      stall_cnt_d = '0;
    end else if (gin_enable && !gin_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // Keeps start_accept referenced when the stall counter is compiled out.
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_gin_tag_sequencer.sv
// Scoreboard bench for gin_tag_sequencer. Expected tagged words are queued when a pass is
// set up and popped as the GIN side transfers them.
module tb_gin_tag_sequencer;

  localparam int DW = 64;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          reset, start, src_valid, src_ready, gin_enable, gin_ready, busy, done;
  logic [RW-1:0] cfg_row_last, gin_row_tag;
  logic [CW-1:0] cfg_col_last, gin_col_tag;
  logic [WW-1:0] cfg_wpt_last;
  logic [DW-1:0] src_data, gin_data;
`ifdef GIN_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  gin_tag_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_row_last (cfg_row_last),
    .cfg_col_last (cfg_col_last),
    .cfg_wpt_last (cfg_wpt_last),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .gin_enable   (gin_enable),
    .gin_data     (gin_data),
    .gin_row_tag  (gin_row_tag),
    .gin_col_tag  (gin_col_tag),
    .gin_ready    (gin_ready),
`ifdef GIN_SEQ_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .busy         (busy),
    .done         (done)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [127:0]  exp_q[$];
  logic [DW-1:0] words[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [DW-1:0] d, input logic [RW-1:0] r,
                                        input logic [CW-1:0] c);
    return {56'd0, d, r, c};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gin_enable"}, 128'(gin_enable), 128'(0));
    check_eq({tag, "_src_ready"}, 128'(src_ready), 128'(0));
    check_eq({tag, "_busy"}, 128'(busy), 128'(0));
    check_eq({tag, "_done"}, 128'(done), 128'(0));
  endtask

  // One pass: rl/cl/wl are the cfg values, vpct/rpct the src_valid/gin_ready duty in percent,
  // stall_n forces gin_ready low for that many presented cycles, abort_at resets after that
  // many accepted words, mid_start pulses start with different cfg while the pass is busy.
  task automatic run_pass(input string name, input int rl, input int cl, input int wl,
                          input int vpct, input int rpct, input int stall_n, input int abort_at,
                          input bit mid_start, input bit rnd);
    int n, k, sidx, xfers, stalls, budget;
    bit ended, aborted, stall_checked;
    n = (rl + 1) * (cl + 1) * (wl + 1);
    words.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      words.push_back(rnd ? {$urandom, $urandom} : DW'(64'hA) + DW'(i));
    end
    k = 0;
    for (int r = 0; r <= rl; r++) begin
      for (int c = 0; c <= cl; c++) begin
        for (int w = 0; w <= wl; w++) begin
          exp_q.push_back(pack(words[k], RW'(r), CW'(c)));
          k++;
        end
      end
    end

    cfg_row_last = RW'(rl);
    cfg_col_last = CW'(cl);
    cfg_wpt_last = WW'(wl);
    start        = 1'b1;
    src_valid    = 1'b0;
    gin_ready    = 1'b0;
    @(posedge clk);
    #1;
    start         = 1'b0;
    sidx          = 0;
    xfers         = 0;
    stalls        = 0;
    ended         = 1'b0;
    aborted       = 1'b0;
    stall_checked = 1'b0;
    budget        = n * 8 + 50;

    for (int cyc = 0; cyc < budget && !ended; cyc++) begin
      src_valid = (sidx < n) && (int'($urandom_range(99)) < vpct);
      src_data  = (sidx < n) ? words[sidx] : '0;
      gin_ready = (stalls >= stall_n) && (int'($urandom_range(99)) < rpct);
      if (mid_start && cyc == 0) begin
        start        = 1'b1;
        cfg_row_last = RW'(3);
        cfg_col_last = CW'(3);
        cfg_wpt_last = WW'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) check_eq({name, "_busy"}, 128'(busy), 128'(1));
      if (stall_n > 0 && stalls == stall_n && !stall_checked) begin
        stall_checked = 1'b1;
        check_eq({name, "_src_ready_full"}, 128'(src_ready), 128'(0));
        check_eq({name, "_accepted_full"}, 128'(sidx), 128'(4));
`ifdef GIN_SEQ_STALL_CNT_EN
        check_eq({name, "_stall_cnt"}, 128'(stall_cnt), 128'(stall_n));
`endif
      end
      if (gin_enable) begin
        if (exp_q.size() == 0) begin
          check_eq({name, "_extra_word"}, 128'(1), 128'(0));
        end else begin
          check_eq({name, "_head"}, pack(gin_data, gin_row_tag, gin_col_tag), exp_q[0]);
        end
        if (gin_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          xfers++;
        end else if (stalls < stall_n) begin
          stalls++;
        end
      end
      if (src_valid && src_ready) sidx++;
      if (done) begin
        ended = 1'b1;
        check_eq({name, "_xfers"}, 128'(xfers), 128'(n));
        check_eq({name, "_left"}, 128'(exp_q.size()), 128'(0));
      end
      if (abort_at > 0 && sidx == abort_at && !ended) begin
        @(posedge clk);
        #1;
        reset     = 1'b1;
        src_valid = 1'b0;
        gin_ready = 1'b0;
        @(negedge clk);
        check_eq({name, "_done_in_reset"}, 128'(done), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs({name, "_after_reset"});
        exp_q.delete();
        ended   = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    if (!ended) begin
      check_eq({name, "_timeout"}, 128'(0), 128'(1));
    end else if (!aborted) begin
      gin_ready = 1'b1;
      src_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_idle_outputs({name, "_post"});
        @(posedge clk);
        #1;
      end
`ifdef GIN_SEQ_STALL_CNT_EN
      if (stall_n > 0) check_eq({name, "_stall_cnt_end"}, 128'(stall_cnt), 128'(stall_n));
`endif
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    src_valid    = 1'b0;
    src_data     = '0;
    gin_ready    = 1'b0;
    cfg_row_last = '0;
    cfg_col_last = '0;
    cfg_wpt_last = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_pass("t1_grid", 1, 2, 0, 100, 100, 0, 0, 1'b0, 1'b1);
    run_pass("t2_wpt", 0, 0, 3, 100, 100, 0, 0, 1'b0, 1'b0);
    run_pass("t3_stall", 0, 0, 7, 100, 100, 10, 0, 1'b0, 1'b1);
    run_pass("t4_abort", 0, 2, 3, 100, 100, 0, 3, 1'b0, 1'b1);
    run_pass("t4_rerun", 0, 2, 3, 100, 100, 0, 0, 1'b0, 1'b1);
    run_pass("t5_zero", 0, 0, 0, 100, 100, 0, 0, 1'b1, 1'b1);
    run_pass("t6_random", 3, 13, 7, 70, 60, 0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
